// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder: write-only I2C target emulating a WM8731-style codec control port.
// Accepts {dev_addr, reg_addr+d8, d[7:0]} writes into a 9-bit register file.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 16,
  parameter logic [6:0] RESET_ADDR = 7'h0F
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       external_interface_SCLK,
  inout  wire        external_interface_SDAT,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  output logic       soft_reset,
  output logic       addr_err,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy
);
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NR = 8'(NUM_REGS);
  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_t;
  state_t st_q, st_d;
  logic [2:0] scl_q, sda_q, cnt_q, cnt_d;
  logic [6:0] sh_q, sh_d, ra_q, ra_d;
  logic d8_q, d8_d, drv_q, drv_d, commit;
  logic scl_rise, scl_fall, start, stop, sda_s;
  logic [8:0] wdat;
  logic [8:0] rf_q [NUM_REGS];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign wdat     = {d8_q, sh_q, sda_s};
  assign busy     = st_q != IDLE;
  assign rd_data  = {1'b0, rd_addr} < NR ? rf_q[rd_addr[AW-1:0]] : '0;
  // Gated by reset so the ACK is dropped the instant reset rises.
  assign external_interface_SDAT = (drv_q & ~reset_reset) ? 1'b0 : 1'bz;
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    ra_d   = ra_q;
    d8_d   = d8_q;
    drv_d  = drv_q;
    commit = 1'b0;
    if (stop) begin
      st_d  = IDLE;
      drv_d = 1'b0;
    end else if (start) begin
      st_d  = ADDR;
      cnt_d = '0;
      drv_d = 1'b0;
    end else begin
      case (st_q)
        ADDR, BYTE1, BYTE2: if (scl_rise) begin
          sh_d  = {sh_q[5:0], sda_s};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            st_d   = st_q == ADDR  ? ((sh_q == DEV_ADDR && !sda_s) ? ACK_A : IGNORE) :
                     st_q == BYTE1 ? ACK_1 : ACK_2;
            commit = st_q == BYTE2;
            if (st_q == BYTE1) {ra_d, d8_d} = {sh_q, sda_s};
          end
        end
        ACK_A, ACK_1, ACK_2: if (scl_fall) begin
          drv_d = !drv_q;
          if (drv_q) begin
            st_d  = st_q == ACK_A ? BYTE1 : st_q == ACK_1 ? BYTE2 : IGNORE;
            cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      scl_q        <= '1;
      sda_q        <= '1;
      st_q         <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      ra_q         <= '0;
      d8_q         <= 1'b0;
      drv_q        <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      soft_reset   <= 1'b0;
      addr_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      scl_q        <= {scl_q[1:0], external_interface_SCLK};
      sda_q        <= {sda_q[1:0], external_interface_SDAT};
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      ra_q         <= ra_d;
      d8_q         <= d8_d;
      drv_q        <= drv_d;
      reg_wr_valid <= 1'b0;
      soft_reset   <= 1'b0;
      addr_err     <= 1'b0;
      if (commit) begin
        if (ra_q == RESET_ADDR) begin
          for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
          soft_reset   <= 1'b1;
          reg_wr_valid <= 1'b1;
          reg_wr_addr  <= ra_q;
          reg_wr_data  <= wdat;
        end else if ({1'b0, ra_q} < NR) begin
          rf_q[ra_q[AW-1:0]] <= wdat;
          reg_wr_valid <= 1'b1;
          reg_wr_addr  <= ra_q;
          reg_wr_data  <= wdat;
        end else begin
          addr_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_codec_responder.sv
// tb_i2c_codec_responder: table vectors, hand sequences and randomized transactions
module tb_i2c_codec_responder;
  localparam int Q = 8;
  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [3:0]  ack;
    int          wv, sr, ae;
    logic [6:0]  wa;
    logic [8:0]  wd;
    logic [6:0]  ra;
    logic [8:0]  rexp;
  } vec_t;
  logic clk = 0, rst = 1, scl = 1, sda_low = 0;
  logic [6:0] rd_addr = 0;
  wire sdat;
  logic wv, sr, ae, busy;
  logic [6:0] wa;
  logic [8:0] wd, rdd;
  int checks = 0, errors = 0, wv_n = 0, sr_n = 0, ae_n = 0;
  int w0, s0, e0, n, ewv, esr, eae;
  logic [3:0] acks, eack;
  logic a, ok;
  logic [7:0] b0, b1, b2, b3;
  logic [6:0] ra;
  logic [8:0] model [16];
  vec_t tv [8];
  always #5 clk = ~clk;
  assign sdat = sda_low ? 1'b0 : 1'bz;
  pullup (sdat);
  i2c_codec_responder dut (
    .clk_clk(clk), .reset_reset(rst), .external_interface_SCLK(scl),
    .external_interface_SDAT(sdat), .reg_wr_valid(wv), .reg_wr_addr(wa),
    .reg_wr_data(wd), .soft_reset(sr), .addr_err(ae), .rd_addr(rd_addr),
    .rd_data(rdd), .busy(busy)
  );
  always @(negedge clk) begin
    if (wv) wv_n++;
    if (sr) sr_n++;
    if (ae) ae_n++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic qd();
    repeat (Q) @(negedge clk);
  endtask
  task automatic start_c();
    sda_low = 0; qd(); scl = 1; qd(); sda_low = 1; qd(); scl = 0; qd();
  endtask
  task automatic stop_c();
    sda_low = 1; qd(); scl = 1; qd(); sda_low = 0; qd();
  endtask
  task automatic send8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_low = ~b[i]; qd(); scl = 1; qd(); qd(); scl = 0; qd();
    end
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic ack);
    send8(b);
    sda_low = 0; qd(); scl = 1; qd();
    ack = (sdat == 1'b0);
    qd(); scl = 0; qd();
  endtask
  task automatic xfer(input logic [31:0] bs, input int cnt, output logic [3:0] ak);
    logic x;
    ak = '0;
    start_c();
    for (int i = 0; i < cnt; i++) begin
      wr_byte(bs[31-8*i -: 8], x);
      ak[i] = x;
    end
    chk("busy_mid", {31'b0, busy}, 1);
    stop_c();
    qd();
    chk("busy_end", {31'b0, busy}, 0);
  endtask
  task automatic rdchk(input string nm, input logic [6:0] ad, input logic [8:0] exp);
    rd_addr = ad;
    #1;
    chk(nm, {23'b0, rdd}, {23'b0, exp});
  endtask
  initial begin
    tv[0] = '{32'h340C1200, 3, 4'b0111, 1, 0, 0, 7'h06, 9'h012, 7'h06, 9'h012};
    tv[1] = '{32'h360C5500, 3, 4'b0000, 0, 0, 0, 7'h00, 9'h000, 7'h06, 9'h012};
    tv[2] = '{32'h350C5500, 3, 4'b0000, 0, 0, 0, 7'h00, 9'h000, 7'h06, 9'h012};
    tv[3] = '{32'h3409FF00, 3, 4'b0111, 1, 0, 0, 7'h04, 9'h1FF, 7'h04, 9'h1FF};
    tv[4] = '{32'h341E0000, 3, 4'b0111, 1, 1, 0, 7'h0F, 9'h000, 7'h04, 9'h000};
    tv[5] = '{32'h340C1277, 4, 4'b0111, 1, 0, 0, 7'h06, 9'h012, 7'h06, 9'h012};
    tv[6] = '{32'h34203300, 3, 4'b0111, 0, 0, 1, 7'h00, 9'h000, 7'h10, 9'h000};
    tv[7] = '{32'h340C0000, 2, 4'b0011, 0, 0, 0, 7'h00, 9'h000, 7'h06, 9'h012};
    repeat (5) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_wv", {31'b0, wv}, 0);
    chk("rst_sr_ae", {30'b0, sr, ae}, 0);
    chk("rst_wa", {25'b0, wa}, 0);
    chk("rst_wd", {23'b0, wd}, 0);
    chk("rst_sdat", {31'b0, sdat}, 1);
    rdchk("rst_rd0", 7'h00, 9'h000);
    rst = 0;
    qd();
    for (int k = 0; k < 8; k++) begin
      w0 = wv_n; s0 = sr_n; e0 = ae_n;
      xfer(tv[k].bytes, tv[k].n, acks);
      chk($sformatf("v%0d_ack", k), {28'b0, acks}, {28'b0, tv[k].ack});
      chk($sformatf("v%0d_wv", k), wv_n - w0, tv[k].wv);
      chk($sformatf("v%0d_sr", k), sr_n - s0, tv[k].sr);
      chk($sformatf("v%0d_ae", k), ae_n - e0, tv[k].ae);
      if (tv[k].wv != 0) begin
        chk($sformatf("v%0d_wa", k), {25'b0, wa}, {25'b0, tv[k].wa});
        chk($sformatf("v%0d_wd", k), {23'b0, wd}, {23'b0, tv[k].wd});
      end
      rdchk($sformatf("v%0d_rd", k), tv[k].ra, tv[k].rexp);
    end
    w0 = wv_n;
    start_c(); wr_byte(8'h34, a); wr_byte(8'h0C, a);
    start_c(); wr_byte(8'h34, a); wr_byte(8'h02, a); wr_byte(8'h80, a);
    chk("rs_ack", {31'b0, a}, 1);
    stop_c(); qd();
    chk("rs_wv", wv_n - w0, 1);
    chk("rs_wa", {25'b0, wa}, 1);
    chk("rs_wd", {23'b0, wd}, 9'h080);
    rdchk("rs_rd1", 7'h01, 9'h080);
    start_c(); wr_byte(8'h34, a); send8(8'h0C);
    sda_low = 0; qd();
    chk("a1_drive", {31'b0, sdat}, 0);
    #2 rst = 1;
    #1;
    chk("ar_sdat", {31'b0, sdat}, 1);
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_strobes", {29'b0, wv, sr, ae}, 0);
    chk("ar_wa", {25'b0, wa}, 0);
    chk("ar_wd", {23'b0, wd}, 0);
    rdchk("ar_rd1", 7'h01, 9'h000);
    scl = 1;
    repeat (4) @(negedge clk);
    rst = 0;
    qd();
    for (int j = 0; j < 16; j++) model[j] = '0;
    for (int t = 0; t < 25; t++) begin
      b0 = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'h34;
      ra = $urandom_range(0, 7) == 0 ? 7'h0F : 7'($urandom_range(0, 19));
      b1 = {ra, 1'($urandom)};
      b2 = 8'($urandom);
      b3 = 8'($urandom);
      n = $urandom_range(1, 4);
      ok = b0 == 8'h34;
      eack = '0;
      for (int i = 0; i < n; i++) eack[i] = ok && i < 3;
      ewv = 0; esr = 0; eae = 0;
      if (ok && n >= 3) begin
        if (ra == 7'h0F) begin
          for (int j = 0; j < 16; j++) model[j] = '0;
          ewv = 1; esr = 1;
        end else if (ra < 16) begin
          model[ra[3:0]] = {b1[0], b2};
          ewv = 1;
        end else eae = 1;
      end
      w0 = wv_n; s0 = sr_n; e0 = ae_n;
      xfer({b0, b1, b2, b3}, n, acks);
      chk($sformatf("r%0d_ack", t), {28'b0, acks}, {28'b0, eack});
      chk($sformatf("r%0d_wv", t), wv_n - w0, ewv);
      chk($sformatf("r%0d_sr", t), sr_n - s0, esr);
      chk($sformatf("r%0d_ae", t), ae_n - e0, eae);
      if (ewv != 0) begin
        chk($sformatf("r%0d_wa", t), {25'b0, wa}, {25'b0, ra});
        chk($sformatf("r%0d_wd", t), {23'b0, wd}, {23'b0, b1[0], b2});
      end
      ra = 7'($urandom_range(0, 19));
      rdchk($sformatf("r%0d_rd", t), ra, ra < 16 ? model[ra[3:0]] : 9'h000);
    end
    for (int j = 0; j < 16; j++) rdchk($sformatf("sweep%0d", j), 7'(j), model[j]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
